vid_timing_gen: RTL and testbench

//  Parametrised successor of the video timing core: programmable H/V counters, blank/sync/active

---
 rtl/vid_pkg.sv | 29 ++
 rtl/vid_sr_flag.sv | 26 ++
 rtl/vid_timing_gen.sv | 170 +++++++++++++++++
 tb/tb_vid_timing_gen.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/vid_pkg.sv
// rtl/vid_pkg.sv - register map, CTRL bit positions and default width for the video timing core
package vid_pkg;
  localparam int CW_DEF   = 11;
  localparam int NUM_TREG = 14;

  localparam logic [4:0] A_HP   = 5'd0;
  localparam logic [4:0] A_HBB  = 5'd1;
  localparam logic [4:0] A_HBE  = 5'd2;
  localparam logic [4:0] A_HDB  = 5'd3;
  localparam logic [4:0] A_HDE  = 5'd4;
  localparam logic [4:0] A_HSS  = 5'd5;
  localparam logic [4:0] A_HSE  = 5'd6;
  localparam logic [4:0] A_VP   = 5'd7;
  localparam logic [4:0] A_VBB  = 5'd8;
  localparam logic [4:0] A_VBE  = 5'd9;
  localparam logic [4:0] A_VDB  = 5'd10;
  localparam logic [4:0] A_VDE  = 5'd11;
  localparam logic [4:0] A_VSS  = 5'd12;
  localparam logic [4:0] A_VSE  = 5'd13;
  localparam int         A_VI0  = 14;
  localparam logic [4:0] A_HC   = 5'd24;
  localparam logic [4:0] A_VC   = 5'd25;
  localparam logic [4:0] A_LPH  = 5'd26;
  localparam logic [4:0] A_LPV  = 5'd27;
  localparam logic [4:0] A_CTRL = 5'd28;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_IMM = 1;
endpackage

// File: rtl/vid_sr_flag.sv
// rtl/vid_sr_flag.sv - enabled set/clear flag flop; clear beats set when both match
module vid_sr_flag (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic set_i,
  input  logic clr_i,
  output logic q_o
);
  logic q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (en_i) begin
      if (clr_i)      q_d = 1'b0;
      else if (set_i) q_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= 1'b0;
    else        q_q <= q_d;
  end

  assign q_o = q_q;
endmodule

// File: rtl/vid_timing_gen.sv
// rtl/vid_timing_gen.sv - programmable H/V timing generator with shadowed timing regs,
// line interrupts and light-pen latch
module vid_timing_gen
  import vid_pkg::*;
#(
  parameter int CW  = CW_DEF,
  parameter int NVI = 2
) (
  input  logic           sys_clk,
  input  logic           resetl,
  input  logic           pix_en,
  input  logic           reg_wr,
  input  logic           reg_rd,
  input  logic [4:0]     reg_addr,
  input  logic [CW-1:0]  reg_din,
  output logic [CW-1:0]  reg_dout,
  input  logic           lp,
  input  logic [NVI-1:0] vint_ack,
  output logic [CW-1:0]  hcount,
  output logic [CW-1:0]  vcount,
  output logic           hblank,
  output logic           vblank,
  output logic           hsync_n,
  output logic           vsync_n,
  output logic           dactive,
  output logic           line_start,
  output logic           frame_start,
  output logic [NVI-1:0] vint,
  output logic           lp_valid
);
  logic [CW-1:0]  stg_q [NUM_TREG];
  logic [CW-1:0]  act_q [NUM_TREG];
  logic [CW-1:0]  vis_q [NVI];
  logic [CW-1:0]  via_q [NVI];
  logic [1:0]     ctrl_q;
  logic [CW-1:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [CW-1:0]  rd_d, dout_q, lph_q, lpv_q;
  logic [NVI-1:0] vint_q, vint_d;
  logic [2:0]     lp_s_q;
  logic           ls_q, fs_q, lpval_q, lpval_d;
  logic           tick, h_wrap, v_wrap, f_wrap, l_tick, act_load;
  logic           lp_edge, lp_clr, lp_latch;
  logic           hb, hs, hd, vb, vs, vd;

  assign tick     = pix_en & ctrl_q[CTRL_EN];
  assign h_wrap   = hcnt_q >= act_q[A_HP];
  assign v_wrap   = vcnt_q >= act_q[A_VP];
  assign l_tick   = tick & h_wrap;
  assign f_wrap   = l_tick & v_wrap;
  assign act_load = f_wrap | ~ctrl_q[CTRL_EN] | ctrl_q[CTRL_IMM];

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (tick) begin
      if (h_wrap) begin
        hcnt_d = '0;
        vcnt_d = v_wrap ? '0 : vcnt_q + CW'(1);
      end else begin
        hcnt_d = hcnt_q + CW'(1);
      end
    end
  end

  // Active copies take the pre-write staging value, so a coincident write waits a frame.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      for (int i = 0; i < NUM_TREG; i++) begin
        stg_q[i] <= '0;
        act_q[i] <= '0;
      end
      for (int k = 0; k < NVI; k++) begin
        vis_q[k] <= '0;
        via_q[k] <= '0;
      end
      ctrl_q <= '0;
    end else begin
      for (int i = 0; i < NUM_TREG; i++) begin
        if (reg_wr && reg_addr == 5'(i)) stg_q[i] <= reg_din;
        if (act_load)                    act_q[i] <= stg_q[i];
      end
      for (int k = 0; k < NVI; k++) begin
        if (reg_wr && reg_addr == 5'(A_VI0 + k)) vis_q[k] <= reg_din;
        if (act_load)                            via_q[k] <= vis_q[k];
      end
      if (reg_wr && reg_addr == A_CTRL) ctrl_q <= reg_din[1:0];
    end
  end

  always_comb begin
    rd_d = '0;
    for (int i = 0; i < NUM_TREG; i++)
      if (reg_addr == 5'(i)) rd_d = stg_q[i];
    for (int k = 0; k < NVI; k++)
      if (reg_addr == 5'(A_VI0 + k)) rd_d = vis_q[k];
    case (reg_addr)
      A_HC:    rd_d = hcnt_q;
      A_VC:    rd_d = vcnt_q;
      A_LPH:   rd_d = lph_q;
      A_LPV:   rd_d = lpv_q;
      A_CTRL:  rd_d = {{(CW-2){1'b0}}, ctrl_q};
      default: ;
    endcase
  end

  always_comb begin
    vint_d = vint_q & ~vint_ack;
    for (int k = 0; k < NVI; k++)
      if (l_tick && vcnt_d == via_q[k]) vint_d[k] = 1'b1;
  end

  assign lp_edge  = lp_s_q[1] & ~lp_s_q[2];
  assign lp_clr   = (reg_rd && reg_addr == A_LPV) | fs_q;
  assign lp_latch = lp_edge & (~lpval_q | lp_clr);
  assign lpval_d  = lp_latch | (lpval_q & ~lp_clr);

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      dout_q  <= '0;
      vint_q  <= '0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      lp_s_q  <= '0;
      lpval_q <= 1'b0;
      lph_q   <= '0;
      lpv_q   <= '0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      vint_q  <= vint_d;
      ls_q    <= l_tick;
      fs_q    <= f_wrap;
      lp_s_q  <= {lp_s_q[1:0], lp};
      lpval_q <= lpval_d;
      if (reg_rd) dout_q <= rd_d;
      if (lp_latch) begin
        lph_q <= hcnt_q;
        lpv_q <= vcnt_q;
      end
    end
  end

  vid_sr_flag u_hb (.clk(sys_clk), .rst_n(resetl), .en_i(tick),
    .set_i(hcnt_q == act_q[A_HBB]), .clr_i(hcnt_q == act_q[A_HBE]), .q_o(hb));
  vid_sr_flag u_hs (.clk(sys_clk), .rst_n(resetl), .en_i(tick),
    .set_i(hcnt_q == act_q[A_HSS]), .clr_i(hcnt_q == act_q[A_HSE]), .q_o(hs));
  vid_sr_flag u_hd (.clk(sys_clk), .rst_n(resetl), .en_i(tick),
    .set_i(hcnt_q == act_q[A_HDB]), .clr_i(hcnt_q == act_q[A_HDE]), .q_o(hd));
  vid_sr_flag u_vb (.clk(sys_clk), .rst_n(resetl), .en_i(l_tick),
    .set_i(vcnt_q == act_q[A_VBB]), .clr_i(vcnt_q == act_q[A_VBE]), .q_o(vb));
  vid_sr_flag u_vs (.clk(sys_clk), .rst_n(resetl), .en_i(l_tick),
    .set_i(vcnt_q == act_q[A_VSS]), .clr_i(vcnt_q == act_q[A_VSE]), .q_o(vs));
  vid_sr_flag u_vd (.clk(sys_clk), .rst_n(resetl), .en_i(l_tick),
    .set_i(vcnt_q == act_q[A_VDB]), .clr_i(vcnt_q == act_q[A_VDE]), .q_o(vd));

  assign hcount      = hcnt_q;
  assign vcount      = vcnt_q;
  assign hblank      = hb;
  assign vblank      = vb;
  assign hsync_n     = ~hs;
  assign vsync_n     = ~vs;
  assign dactive     = ~hb & ~vb & hd & vd;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign vint        = vint_q;
  assign lp_valid    = lpval_q;
  assign reg_dout    = dout_q;
endmodule

// File: tb/tb_vid_timing_gen.sv
// tb/tb_vid_timing_gen.sv - directed self-checking bench for vid_timing_gen
module tb_vid_timing_gen;
  logic        sys_clk = 1'b0;
  logic        resetl, pix_en, reg_wr, reg_rd, lp;
  logic [4:0]  reg_addr;
  logic [10:0] reg_din, reg_dout, hcount, vcount;
  logic [1:0]  vint_ack, vint;
  logic        hblank, vblank, hsync_n, vsync_n, dactive, line_start, frame_start, lp_valid;
  int          total = 0;
  int          bad = 0;
  int          n;
  logic [10:0] d;
  logic        hb_any;

  always #5 sys_clk = ~sys_clk;

  vid_timing_gen #(.CW(11), .NVI(2)) dut (
    .sys_clk(sys_clk), .resetl(resetl), .pix_en(pix_en), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_addr(reg_addr), .reg_din(reg_din), .reg_dout(reg_dout), .lp(lp), .vint_ack(vint_ack),
    .hcount(hcount), .vcount(vcount), .hblank(hblank), .vblank(vblank), .hsync_n(hsync_n),
    .vsync_n(vsync_n), .dactive(dactive), .line_start(line_start), .frame_start(frame_start),
    .vint(vint), .lp_valid(lp_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [10:0] v);
    reg_addr = a; reg_din = v; reg_wr = 1'b1;
    @(posedge sys_clk); @(negedge sys_clk);
    reg_wr = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [10:0] v);
    reg_addr = a; reg_rd = 1'b1;
    @(posedge sys_clk); @(negedge sys_clk);
    reg_rd = 1'b0;
    v = reg_dout;
  endtask

  task automatic wait_hv(input int h, input int v);
    int k = 0;
    while (!(int'(hcount) == h && (v < 0 || int'(vcount) == v)) && k < 300) begin
      @(negedge sys_clk); k++;
    end
    if (k >= 300) chk("wait_hv_timeout", 0, 1);
  endtask

  task automatic wait_fs();
    int k = 0;
    do begin @(negedge sys_clk); k++; end while (!frame_start && k < 300);
    if (!frame_start) chk("wait_fs_timeout", 0, 1);
  endtask

  task automatic gap(output int len);
    len = 0;
    do begin @(negedge sys_clk); len++; end while (!line_start && len < 200);
  endtask

  initial begin
    resetl = 1'b0; pix_en = 1'b0; reg_wr = 1'b0; reg_rd = 1'b0; lp = 1'b0;
    reg_addr = '0; reg_din = '0; vint_ack = '0;
    repeat (2) @(negedge sys_clk);
    chk("rst_hcount", hcount, 0);   chk("rst_vcount", vcount, 0);
    chk("rst_hblank", hblank, 0);   chk("rst_vblank", vblank, 0);
    chk("rst_hsync_n", hsync_n, 1); chk("rst_vsync_n", vsync_n, 1);
    chk("rst_dactive", dactive, 0); chk("rst_line_start", line_start, 0);
    chk("rst_frame_start", frame_start, 0); chk("rst_vint", vint, 0);
    chk("rst_lp_valid", lp_valid, 0); chk("rst_reg_dout", reg_dout, 0);
    resetl = 1'b1; pix_en = 1'b1;
    @(negedge sys_clk);

    // basic 10x5 raster
    wr(5'd0, 11'd9); wr(5'd1, 11'd7); wr(5'd2, 11'd1);
    wr(5'd5, 11'd8); wr(5'd6, 11'd9); wr(5'd7, 11'd4);
    wr(5'd28, 11'd1);
    wait_fs();
    for (int i = 0; i < 50; i++) begin
      chk("ras_hcount", hcount, i % 10);
      chk("ras_vcount", vcount, i / 10);
      chk("ras_hblank", hblank, (i % 10 >= 8 || i % 10 <= 1) ? 1 : 0);
      chk("ras_hsync_n", hsync_n, (i % 10 == 9) ? 0 : 1);
      chk("ras_line_start", line_start, (i % 10 == 0) ? 1 : 0);
      chk("ras_frame_start", frame_start, (i == 0) ? 1 : 0);
      @(negedge sys_clk);
    end
    chk("ras_frame_period", frame_start, 1);

    // shadowed HP change waits for the frame wrap
    wait_hv(3, 2);
    wr(5'd0, 11'd5);
    gap(n);
    gap(n); chk("shadow_len_same_frame", n, 10);
    wait_fs();
    gap(n); chk("shadow_len_next_frame", n, 6);

    // IMM: change takes effect from the next line
    wr(5'd28, 11'd3);
    wr(5'd0, 11'd9);
    gap(n); gap(n); chk("imm_len_restore", n, 10);
    wait_hv(2, -1);
    wr(5'd0, 11'd5);
    gap(n); chk("imm_len_partial", n, 3);
    gap(n); chk("imm_len_next", n, 6);

    // period shrunk below current count wraps on the next tick
    wr(5'd0, 11'd9);
    gap(n);
    wait_hv(5, -1);
    wr(5'd0, 11'd2);
    @(negedge sys_clk); chk("shrink_h7", hcount, 7);
    @(negedge sys_clk); chk("shrink_wrap_h", hcount, 0);
    chk("shrink_wrap_ls", line_start, 1);
    gap(n); chk("shrink_len", n, 3);

    // full timing set
    wr(5'd0, 11'd9);  wr(5'd1, 11'd3);  wr(5'd2, 11'd3);
    wr(5'd3, 11'd1);  wr(5'd4, 11'd5);
    wr(5'd8, 11'd3);  wr(5'd9, 11'd0);  wr(5'd10, 11'd1); wr(5'd11, 11'd3);
    wr(5'd12, 11'd4); wr(5'd13, 11'd0); wr(5'd14, 11'd3); wr(5'd15, 11'd3);
    wait_fs(); wait_fs();
    hb_any = 1'b0;
    for (int i = 0; i < 50; i++) begin
      hb_any = hb_any | hblank;
      @(negedge sys_clk);
    end
    chk("hblank_start_eq_end", hb_any, 0);
    wait_hv(3, 1); chk("v1_vblank", vblank, 0); chk("v1_dactive", dactive, 0);
    chk("v1_vsync_n", vsync_n, 1);
    wait_hv(3, 2); chk("h3v2_dactive", dactive, 1);
    wait_hv(7, 2); chk("h7v2_dactive", dactive, 0);
    wait_hv(5, 4); chk("v4_vblank", vblank, 1); chk("v4_vsync_n", vsync_n, 1);
    wait_hv(5, 0); chk("v0_vblank", vblank, 1); chk("v0_vsync_n", vsync_n, 0);
    chk("v0_dactive", dactive, 0);

    // line interrupts
    wait_hv(5, 1);
    vint_ack = 2'b11; @(negedge sys_clk); vint_ack = 2'b00;
    chk("vint_cleared", vint, 0);
    wait_hv(9, 2);
    vint_ack = 2'b01; @(negedge sys_clk); vint_ack = 2'b00;
    chk("vint_set_wins", vint, 2'b11); chk("vint_set_vcount", vcount, 3);
    @(negedge sys_clk);
    vint_ack = 2'b01; @(negedge sys_clk); vint_ack = 2'b00;
    chk("vint_ack_ch0", vint, 2'b10);

    // light pen
    wait_hv(4, 2); lp = 1'b1;
    wait_hv(8, 2); lp = 1'b0;
    wait_hv(4, 3); lp = 1'b1;
    wait_hv(8, 3); lp = 1'b0;
    chk("lp_valid_set", lp_valid, 1);
    rd(5'd26, d); chk("lp_lph", d, 6);
    rd(5'd27, d); chk("lp_lpv", d, 2);
    chk("lp_valid_rdclr", lp_valid, 0);

    // register reads
    wait_hv(3, 1);
    rd(5'd24, d); chk("rd_hc", d, 3);
    rd(5'd0, d);  chk("rd_hp", d, 9);
    rd(5'd20, d); chk("rd_unmapped", d, 0);
    rd(5'd28, d); chk("rd_ctrl", d, 3);

    // asynchronous reset mid-line
    wait_hv(3, 2);
    chk("pre_rst_dactive", dactive, 1);
    resetl = 1'b0;
    #1;
    chk("arst_hcount", hcount, 0);   chk("arst_vcount", vcount, 0);
    chk("arst_dactive", dactive, 0); chk("arst_hsync_n", hsync_n, 1);
    chk("arst_vint", vint, 0);       chk("arst_reg_dout", reg_dout, 0);
    chk("arst_line_start", line_start, 0);
    @(negedge sys_clk);
    resetl = 1'b1;
    repeat (5) @(negedge sys_clk);
    chk("en0_hcount", hcount, 0); chk("en0_vcount", vcount, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
